div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
- REQ-001 Parameters: none; widths fixed at 16-bit dividend, 8-bit divisor.
- REQ-002 clk_i  input  1  clock; all state changes on rising edge.
- REQ-003 rst_i  input  1  synchronous, active-high reset.
- REQ-004 a_bi  input  16  dividend, unsigned; sampled only when a start is accepted.
- REQ-005 b_bi  input  8  divisor, unsigned; sampled only when a start is accepted.
- REQ-006 start_i  input  1  request; honoured only while IDLE.
- REQ-007 busy_o  output  1  high while the FSM is in WORK.
- REQ-008 q_bo  output  16  quotient, registered.
- REQ-009 r_bo  output  8  remainder, registered.
- REQ-010 done_o  output  1  one-cycle pulse; q_bo/r_bo/dz_o are valid from that cycle on.
- REQ-011 dz_o  output  1  divide-by-zero flag for the last completed operation.

Function
- REQ-012 The FSM SHALL have two states, IDLE and WORK; busy_o SHALL equal (state==WORK).
- REQ-013 IDLE with start_i=1 at edge E0 SHALL latch a_bi and b_bi, clear the partial remainder and the 4-bit step counter, and enter WORK.
- REQ-014 Each WORK cycle SHALL do one restoring step: p[8:0]={rem,dividend MSB}; shift dividend left; if p>=divisor then rem=p-divisor and shift in quotient bit 1, else rem=p[7:0] and shift in 0.
- REQ-015 After exactly 16 WORK cycles (edge E16, counter==15): load q_bo/r_bo, set dz_o=(divisor==0), pulse done_o high for one cycle, return to IDLE.
- REQ-016 busy_o SHALL be high from E0 through E16; latency is a constant 16 cycles from acceptance to valid outputs, divisor value irrelevant.
- REQ-017 Divisor 0 SHALL use the same datapath with rem truncated to 8 bits, giving q_bo=16'hFFFF, r_bo=a_bi[7:0], dz_o=1.
- REQ-018 start_i while in WORK SHALL be ignored; latched operands SHALL NOT change.
- REQ-019 start_i high in the done_o cycle (IDLE) SHALL be accepted, so back-to-back operations cost 17 cycles each.
- REQ-020 q_bo, r_bo and dz_o SHALL hold their values until the next completion; done_o SHALL be 0 at all other times.
- REQ-021 For divisor!=0: a_bi == q_bo*b_bi + r_bo and r_bo < b_bi.

Reset
- REQ-022 rst_i=1 SHALL force IDLE, busy_o=0, done_o=0, dz_o=0, q_bo=0, r_bo=0 and counter=0 at the next edge.
- REQ-023 Reset SHALL take priority over start_i and over any in-flight operation; an aborted operation produces no done_o.

Structure
- REQ-024 The shared package/header SHALL hold the IDLE/WORK encodings, DIVIDEND_W=16, DIVISOR_W=8 and STEPS=16.
- REQ-025 One combinational sub-module div_step SHALL compute one restoring step: inputs rem and next bit; outputs new rem and quotient bit.

Verification
- REQ-026 a=1000, b=7 -> done_o 16 cycles after acceptance, q=142, r=6, dz=0.
- REQ-027 a=65535, b=255 -> q=257, r=0; a=5, b=10 -> q=0, r=5.
- REQ-028 a=16'h1234, b=0 -> q=16'hFFFF, r=8'h34, dz=1, latency still 16.
- REQ-029 a=100, b=3 accepted, then start_i with a=9, b=9 at cycle 5 -> ignored; result q=33, r=1.
- REQ-030 rst_i pulsed at cycle 8 of an operation -> all outputs 0, busy_o=0, no done_o; a new start at the following edge completes normally.
- REQ-031 start_i held high continuously with random operands -> one done_o every 17 cycles; every result satisfies REQ-021.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and widths for the restoring divider
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int STEPS      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] p;

    assign p     = {rem, bit_in};
    assign q_bit = (p >= {1'b0, divisor});
    // A zero divisor always subtracts nothing, so rem just truncates to 8 bits.
    assign rem_next = q_bit ? DIVISOR_W'(p - {1'b0, divisor}) : p[DIVISOR_W-1:0];

endmodule

// File: rtl/div.sv
// rtl/div.sv - 16/8 unsigned sequential restoring divider, fixed 16-cycle latency
module div
    import div_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIVIDEND_W-1:0] a_bi,
    input  logic [DIVISOR_W-1:0]  b_bi,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic [DIVIDEND_W-1:0] q_bo,
    output logic [DIVISOR_W-1:0]  r_bo,
    output logic                  done_o,
    output logic                  dz_o
);

    state_t                state;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  rem_nx;
    logic                  q_bit;
    logic [3:0]            cnt;

    div_step u_step (
        .rem      (rem),
        .bit_in   (dvd[DIVIDEND_W-1]),
        .divisor  (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    assign busy_o = (state == WORK);

    // The dividend register shifts out its MSB and shifts in quotient bits,
    // so after the last step it holds the full quotient.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            q_bo   <= '0;
            r_bo   <= '0;
            dz_o   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dvd   <= a_bi;
                        dvs   <= b_bi;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= WORK;
                    end
                end
                WORK: begin
                    dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
                    rem <= rem_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(STEPS - 1)) begin
                        q_bo   <= {dvd[DIVIDEND_W-2:0], q_bit};
                        r_bo   <= rem_nx;
                        dz_o   <= (dvs == '0);
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard testbench for the div restoring divider
module tb_div;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] a_bi = '0;
    logic [7:0]  b_bi = '0;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic [15:0] q_bo;
    logic [7:0]  r_bo;
    logic        done_o;
    logic        dz_o;

    div dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .q_bo    (q_bo),
        .r_bo    (r_bo),
        .done_o  (done_o),
        .dz_o    (dz_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_expected = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input logic [15:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        if (b == 8'd0) begin
            e.q  = 16'hFFFF;
            e.r  = a[7:0];
            e.dz = 1'b1;
        end else begin
            e.q  = a / {8'd0, b};
            e.r  = 8'(a % {8'd0, b});
            e.dz = 1'b0;
        end
        e.acc = acc;
        exp_q.push_back(e);
        n_expected++;
    endfunction

    always @(negedge clk_i) begin
        if (done_o) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("q", 32'(q_bo), 32'(e.q));
                check("r", 32'(r_bo), 32'(e.r));
                check("dz", 32'(dz_o), 32'(e.dz));
                check("latency", 32'(cyc - e.acc), 32'd16);
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk_i);
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        push_exp(a, b, cyc);
        start_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_q", 32'(q_bo), 32'd0);
        check("rst_r", 32'(r_bo), 32'd0);
        check("rst_dz", 32'(dz_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        start_op(16'd1000, 8'd7);
        check("busy_e0", 32'(busy_o), 32'd1);
        repeat (15) @(posedge clk_i);
        #1;
        check("busy_e15", 32'(busy_o), 32'd1);
        check("done_early", 32'(done_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("busy_e16", 32'(busy_o), 32'd0);
        check("done_e16", 32'(done_o), 32'd1);
        wait_drain();
        @(posedge clk_i);
        #1;
        check("done_pulse", 32'(done_o), 32'd0);
        check("hold_q", 32'(q_bo), 32'd142);

        start_op(16'd65535, 8'd255);
        wait_drain();
        start_op(16'd5, 8'd10);
        wait_drain();
        start_op(16'h1234, 8'd0);
        wait_drain();
        start_op(16'h00FF, 8'd1);
        wait_drain();

        start_op(16'd100, 8'd3);
        repeat (4) @(negedge clk_i);
        a_bi    = 16'd9;
        b_bi    = 8'd9;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_drain();

        start_op(16'd500, 8'd9);
        repeat (7) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        n_expected--;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_q", 32'(q_bo), 32'd0);
        check("abort_r", 32'(r_bo), 32'd0);
        check("abort_dz", 32'(dz_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        start_op(16'd4321, 8'd17);
        wait_drain();

        for (int k = 0; k < 102; k++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            @(negedge clk_i);
            ra      = 16'($urandom);
            rb      = (k == 34) ? 8'd0 : 8'($urandom_range(1, 255));
            a_bi    = ra;
            b_bi    = rb;
            start_i = 1'b1;
            @(posedge clk_i);
            #1;
            if (k % 17 == 0) push_exp(ra, rb, cyc);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        wait_drain();
        repeat (20) @(posedge clk_i);
        #1;
        check("done_count", 32'(n_done), 32'(n_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
